// File: rtl/perf_mon_pkg.sv
// Shared types for the ap_ctrl performance monitor: read field selects, channel FSM states, status word layout.
// No logic; used by the RTL and the bench.
// The status word is {state[1:0], ovf, unf, fifo_level[LEVEL_W-1:0]}; LEVEL_W covers OUTSTANDING up to 128.
package perf_mon_pkg;

  typedef enum logic [2:0] {
    F_TXN_CNT       = 3'd0,
    F_LAST_LAT      = 3'd1,
    F_MIN_LAT       = 3'd2,
    F_MAX_LAT       = 3'd3,
    F_LAST_INTERVAL = 3'd4,
    F_STALL_CNT     = 3'd5,
    F_STATUS        = 3'd6,
    F_TS            = 3'd7
  } field_e;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_BUSY      = 2'd1,
    ST_DONE_WAIT = 2'd2
  } ch_state_e;

  localparam int LEVEL_W  = 8;
  localparam int STATUS_W = 2 + 1 + 1 + LEVEL_W;

  function automatic logic [STATUS_W-1:0] pack_status(input ch_state_e st, input logic ovf,
                                                      input logic unf, input logic [LEVEL_W-1:0] lvl);
    return {st, ovf, unf, lvl};
  endfunction

endpackage

// File: rtl/ts_fifo.sv
// Timestamp FIFO, W x DEPTH (DEPTH power of 2); push/pop/same-cycle push+pop, sync clear, full/empty/level.
// Latency: dout shows the head combinationally from registered storage; a push is visible the next cycle.
// Backpressure: push while full is dropped unless a pop happens in the same cycle; pop while empty is ignored.
// Ports: clock, reset (async active-low), clear, push, pop, din -> dout, full, empty, level.
module ts_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int LW   = AW + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clear,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full  = (cnt_q == LW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign level = cnt_q;
  assign dout  = mem_q[rd_q];

  // The old head leaves before the new entry lands, so a full FIFO can accept a push alongside a pop.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (clear) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_q] = din;
        wr_d        = wr_q + 1'b1;
      end
      if (do_pop) rd_d = rd_q + 1'b1;
      cnt_d = cnt_q + LW'(do_push) - LW'(do_pop);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ap_ctrl_perf_monitor.sv
// Per-channel ap_ctrl_chain performance monitor: txn count, last/min/max latency, start-to-start interval, status.
// Latency: rd_valid/rd_data exactly 1 cycle after rd_req, showing stats from before that cycle's events.
// Backpressure: none on the read port; ap_continue low holds a channel in DONE_WAIT (counted as stall).
// Ports: clock, reset (async active-low); per-channel ap_start/ap_ready/ap_done/ap_continue; clear (sync wipe,
// ts keeps running); finish (freeze events); rd_req/rd_ch/rd_field -> rd_valid/rd_data.
// Build option: define PERF_MON_STALL_EN to enable per-channel stall_cnt; otherwise field 5 reads 0.
module ap_ctrl_perf_monitor
  import perf_mon_pkg::*;
#(
  parameter int  NUM_CH      = 4,
  parameter int  CNT_W       = 32,
  parameter int  OUTSTANDING = 4,
  localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NUM_CH-1:0] ap_start,
  input  logic [NUM_CH-1:0] ap_ready,
  input  logic [NUM_CH-1:0] ap_done,
  input  logic [NUM_CH-1:0] ap_continue,
  input  logic              clear,
  input  logic              finish,
  input  logic              rd_req,
  input  logic [CH_W-1:0]   rd_ch,
  input  logic [2:0]        rd_field,
  output logic              rd_valid,
  output logic [CNT_W-1:0]  rd_data
);

  localparam int LVL_W = $clog2(OUTSTANDING) + 1;
  localparam int NSLOT = 1 << CH_W;

  // Free-running timestamp; wraps, and all latency/interval math is modulo 2^CNT_W.
  logic [CNT_W-1:0] ts_q, ts_d;
  assign ts_d = ts_q + 1'b1;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) ts_q <= '0;
    else        ts_q <= ts_d;
  end

  // Per-slot views for the read mux; slots beyond NUM_CH read as zero.
  logic [CNT_W-1:0]    txn_a   [NSLOT];
  logic [CNT_W-1:0]    last_a  [NSLOT];
  logic [CNT_W-1:0]    min_a   [NSLOT];
  logic [CNT_W-1:0]    max_a   [NSLOT];
  logic [CNT_W-1:0]    int_a   [NSLOT];
  logic [CNT_W-1:0]    stall_a [NSLOT];
  logic [STATUS_W-1:0] stat_a  [NSLOT];

  for (genvar g = 0; g < NSLOT; g++) begin : g_ch
    if (g < NUM_CH) begin : g_real
      logic             accept, complete, waiting, has_lat, push, pop, full, empty;
      logic [CNT_W-1:0] head, lat;
      logic [LVL_W-1:0] level, level_nxt;
      ch_state_e        state_q, state_d;
      logic [CNT_W-1:0] txn_q, txn_d, last_q, last_d, min_q, min_d, max_q, max_d;
      logic [CNT_W-1:0] int_q, int_d, acc_ts_q, acc_ts_d;
      logic             seen_q, seen_d, ovf_q, ovf_d, unf_q, unf_d;

      assign accept   = ap_start[g] & ap_ready[g] & ~finish;
      assign complete = ap_done[g] & ap_continue[g] & ~finish;
      assign waiting  = ap_done[g] & ~ap_continue[g] & ~finish;

      // Pop-then-push: with an empty FIFO a same-cycle accept+complete is one zero-latency
      // transaction, so nothing is stored for it.
      assign pop       = complete & ~empty;
      assign push      = accept & ~(complete & empty) & (~full | complete);
      assign has_lat   = complete & (~empty | accept);
      assign lat       = empty ? '0 : ts_q - head;
      assign level_nxt = level + LVL_W'(push) - LVL_W'(pop);

      ts_fifo #(.W(CNT_W), .DEPTH(OUTSTANDING)) u_fifo (
        .clock (clock),
        .reset (reset),
        .clear (clear),
        .push  (push),
        .pop   (pop),
        .din   (ts_q),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .level (level)
      );

      always_comb begin
        state_d  = state_q;
        txn_d    = txn_q;
        last_d   = last_q;
        min_d    = min_q;
        max_d    = max_q;
        int_d    = int_q;
        acc_ts_d = acc_ts_q;
        seen_d   = seen_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        if (clear) begin
          state_d  = ST_IDLE;
          txn_d    = '0;
          last_d   = '0;
          min_d    = '1;
          max_d    = '0;
          int_d    = '0;
          acc_ts_d = '0;
          seen_d   = 1'b0;
          ovf_d    = 1'b0;
          unf_d    = 1'b0;
        end else begin
          // Interval is tracked on every accept, including ones whose timestamp is dropped.
          if (accept) begin
            if (seen_q) int_d = ts_q - acc_ts_q;
            acc_ts_d = ts_q;
            seen_d   = 1'b1;
          end
          if (has_lat) begin
            last_d = lat;
            if (lat < min_q) min_d = lat;
            if (lat > max_q) max_d = lat;
            if (txn_q != '1) txn_d = txn_q + 1'b1;
          end
          if (complete & empty & ~accept) unf_d = 1'b1;
          if (accept & full & ~complete)  ovf_d = 1'b1;

          unique case (state_q)
            ST_IDLE: begin
              if (accept) begin
                if (waiting)                            state_d = ST_DONE_WAIT;
                else if (complete && level_nxt == '0)   state_d = ST_IDLE;
                else                                    state_d = ST_BUSY;
              end
            end
            ST_BUSY: begin
              if (waiting)                              state_d = ST_DONE_WAIT;
              else if (complete && level_nxt == '0)     state_d = ST_IDLE;
            end
            ST_DONE_WAIT: begin
              if (complete) state_d = (level_nxt != '0) ? ST_BUSY : ST_IDLE;
            end
            default: state_d = ST_IDLE;
          endcase
        end
      end

      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          state_q  <= ST_IDLE;
          txn_q    <= '0;
          last_q   <= '0;
          min_q    <= '1;
          max_q    <= '0;
          int_q    <= '0;
          acc_ts_q <= '0;
          seen_q   <= 1'b0;
          ovf_q    <= 1'b0;
          unf_q    <= 1'b0;
        end else begin
          state_q  <= state_d;
          txn_q    <= txn_d;
          last_q   <= last_d;
          min_q    <= min_d;
          max_q    <= max_d;
          int_q    <= int_d;
          acc_ts_q <= acc_ts_d;
          seen_q   <= seen_d;
          ovf_q    <= ovf_d;
          unf_q    <= unf_d;
        end
      end

`ifdef PERF_MON_STALL_EN
      // One count per cycle, whether the channel waits on ap_continue, on ap_ready, or both.
      logic [CNT_W-1:0] stall_q, stall_d;
      always_comb begin
        stall_d = stall_q;
        if (clear) begin
          stall_d = '0;
        end else if (!finish && (state_q == ST_DONE_WAIT || (ap_start[g] && !ap_ready[g]))
                     && stall_q != '1) begin
          stall_d = stall_q + 1'b1;
        end
      end
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) stall_q <= '0;
        else        stall_q <= stall_d;
      end
      assign stall_a[g] = stall_q;
`else
      assign stall_a[g] = '0;
`endif

      assign txn_a[g]  = txn_q;
      assign last_a[g] = last_q;
      assign min_a[g]  = min_q;
      assign max_a[g]  = max_q;
      assign int_a[g]  = int_q;
      assign stat_a[g] = pack_status(state_q, ovf_q, unf_q, LEVEL_W'(level));
    end else begin : g_pad
      assign txn_a[g]   = '0;
      assign last_a[g]  = '0;
      assign min_a[g]   = '0;
      assign max_a[g]   = '0;
      assign int_a[g]   = '0;
      assign stall_a[g] = '0;
      assign stat_a[g]  = '0;
    end
  end

  // Registered read port.
  logic             rd_valid_q, rd_valid_d;
  logic [CNT_W-1:0] rd_data_q, rd_data_d;

  always_comb begin
    rd_valid_d = rd_req;
    rd_data_d  = '0;
    if (rd_req && (int'(rd_ch) < NUM_CH)) begin
      case (field_e'(rd_field))
        F_TXN_CNT:       rd_data_d = txn_a[rd_ch];
        F_LAST_LAT:      rd_data_d = last_a[rd_ch];
        F_MIN_LAT:       rd_data_d = min_a[rd_ch];
        F_MAX_LAT:       rd_data_d = max_a[rd_ch];
        F_LAST_INTERVAL: rd_data_d = int_a[rd_ch];
        F_STALL_CNT:     rd_data_d = stall_a[rd_ch];
        F_STATUS:        rd_data_d = CNT_W'(stat_a[rd_ch]);
        F_TS:            rd_data_d = ts_q;
        default:         rd_data_d = '0;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_ap_ctrl_perf_monitor.sv
// Bench for ap_ctrl_perf_monitor (NUM_CH=3, CNT_W=12, OUTSTANDING=4).
// Reads push their expected value into a scoreboard queue; the monitor pops on rd_valid and compares.
module tb_ap_ctrl_perf_monitor;
  import perf_mon_pkg::*;

  localparam int NUM_CH = 3;
  localparam int CNT_W  = 12;
  localparam int OUTST  = 4;

  logic              clock;
  logic              reset;
  logic [NUM_CH-1:0] ap_start, ap_ready, ap_done, ap_continue;
  logic              clear, finish, rd_req;
  logic [1:0]        rd_ch;
  logic [2:0]        rd_field;
  logic              rd_valid;
  logic [CNT_W-1:0]  rd_data;

  ap_ctrl_perf_monitor #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .OUTSTANDING(OUTST)) dut (
    .clock       (clock),
    .reset       (reset),
    .ap_start    (ap_start),
    .ap_ready    (ap_ready),
    .ap_done     (ap_done),
    .ap_continue (ap_continue),
    .clear       (clear),
    .finish      (finish),
    .rd_req      (rd_req),
    .rd_ch       (rd_ch),
    .rd_field    (rd_field),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Bench-side timestamp: the cycle number the DUT should be stamping events with.
  logic [CNT_W-1:0] cyc;
  always @(posedge clock or negedge reset) begin
    if (!reset) cyc <= '0;
    else        cyc <= cyc + 1'b1;
  end

  logic [CNT_W-1:0] exp_q[$];
  string            nm_q[$];
  logic [CNT_W-1:0] mon_exp;
  string            mon_nm;

  always @(negedge clock) begin
    if (rd_valid === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_rd_valid: got data=%0h required no response", rd_data);
      end else begin
        mon_exp = exp_q.pop_front();
        mon_nm  = nm_q.pop_front();
        if (rd_data !== mon_exp) begin
          bad++;
          $display("FAIL %s: got %0h required %0h", mon_nm, rd_data, mon_exp);
        end
      end
    end
  end

  function automatic logic [CNT_W-1:0] stv(input ch_state_e s, input logic o, input logic u, input int lvl);
    logic [7:0] l;
    l = 8'(lvl);
    return {s, o, u, l};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_ts(input int n);
    int k;
    k = 0;
    while (cyc != CNT_W'(n)) begin
      tick();
      k++;
      if (k > 5000) begin
        total++;
        bad++;
        $display("FAIL wait_ts_timeout: got ts=%0d required %0d", cyc, n);
        return;
      end
    end
  endtask

  task automatic issue_read(input int ch, input field_e f, input logic [CNT_W-1:0] e, input string nm);
    rd_req   = 1'b1;
    rd_ch    = 2'(ch);
    rd_field = f;
    exp_q.push_back(e);
    nm_q.push_back(nm);
    tick();
    rd_req = 1'b0;
  endtask

  task automatic pulse(input int ch, input bit s, input bit r, input bit d);
    ap_start[ch] = s;
    ap_ready[ch] = r;
    ap_done[ch]  = d;
    tick();
    ap_start[ch] = 1'b0;
    ap_ready[ch] = 1'b0;
    ap_done[ch]  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clock);
    total++;
    if (rd_valid !== 1'b0) begin bad++; $display("FAIL reset_rd_valid: got %0b required 0", rd_valid); end
    total++;
    if (rd_data !== '0) begin bad++; $display("FAIL reset_rd_data: got %0h required 0", rd_data); end
    reset = 1'b1;
    tick();
    issue_read(0, F_TXN_CNT, 0, "reset_txn");
    issue_read(0, F_MIN_LAT, '1, "reset_min");
    issue_read(1, F_STATUS, 0, "reset_status");
    issue_read(2, F_STALL_CNT, 0, "reset_stall");
    issue_read(0, F_TS, cyc, "reset_ts");
  endtask

  task automatic test_single();
    wait_ts(10); pulse(0, 1, 1, 0);
    issue_read(0, F_STATUS, stv(ST_BUSY, 0, 0, 1), "single_busy");
    wait_ts(25); pulse(0, 0, 0, 1);
    issue_read(0, F_TXN_CNT, 1, "single_txn");
    issue_read(0, F_LAST_LAT, 15, "single_last");
    issue_read(0, F_MIN_LAT, 15, "single_min");
    issue_read(0, F_MAX_LAT, 15, "single_max");
    issue_read(0, F_STATUS, stv(ST_IDLE, 0, 0, 0), "single_idle");
  endtask

  task automatic test_overlap();
    for (int i = 0; i < 4; i++) begin wait_ts(35 + 2 * i); pulse(1, 1, 1, 0); end
    issue_read(1, F_STATUS, stv(ST_BUSY, 0, 0, 4), "overlap_level4");
    wait_ts(50);
    ap_done[1] = 1'b1;
    repeat (4) tick();
    ap_done[1] = 1'b0;
    issue_read(1, F_TXN_CNT, 4, "overlap_txn");
    issue_read(1, F_LAST_LAT, 12, "overlap_last");
    issue_read(1, F_MIN_LAT, 12, "overlap_min");
    issue_read(1, F_MAX_LAT, 15, "overlap_max");
    issue_read(1, F_LAST_INTERVAL, 2, "overlap_interval");
    issue_read(1, F_STATUS, stv(ST_IDLE, 0, 0, 0), "overlap_idle");
  endtask

  task automatic test_overflow();
    wait_ts(70);
    ap_start[2] = 1'b1; ap_ready[2] = 1'b1;
    repeat (5) tick();
    ap_start[2] = 1'b0; ap_ready[2] = 1'b0;
    issue_read(2, F_STATUS, stv(ST_BUSY, 1, 0, 4), "ovf_status");
    wait_ts(80); pulse(2, 0, 0, 1);
    issue_read(2, F_LAST_LAT, 10, "ovf_lat_first");
    issue_read(2, F_TXN_CNT, 1, "ovf_txn");
    issue_read(2, F_STATUS, stv(ST_BUSY, 1, 0, 3), "ovf_level3");
    issue_read(2, F_LAST_INTERVAL, 1, "ovf_interval");
  endtask

  task automatic test_same_cycle();
    wait_ts(100); pulse(1, 1, 1, 1);
    issue_read(1, F_LAST_LAT, 0, "same_lat0");
    issue_read(1, F_MIN_LAT, 0, "same_min");
    issue_read(1, F_TXN_CNT, 5, "same_txn");
    issue_read(1, F_LAST_INTERVAL, 100 - 41, "same_interval");
    issue_read(1, F_STATUS, stv(ST_IDLE, 0, 0, 0), "same_status");
  endtask

  task automatic test_underflow();
    wait_ts(120); pulse(0, 0, 0, 1);
    issue_read(0, F_STATUS, stv(ST_IDLE, 0, 1, 0), "unf_status");
    issue_read(0, F_TXN_CNT, 1, "unf_txn");
  endtask

  task automatic test_finish();
    wait_ts(130);
    finish = 1'b1;
    ap_start[1] = 1'b1; ap_ready[1] = 1'b1; ap_done[0] = 1'b1;
    tick();
    ap_start[1] = 1'b0; ap_ready[1] = 1'b0; ap_done[0] = 1'b0;
    issue_read(1, F_TXN_CNT, 5, "finish_read_works");
    finish = 1'b0;
    issue_read(1, F_STATUS, stv(ST_IDLE, 0, 0, 0), "finish_status");
    issue_read(1, F_LAST_INTERVAL, 59, "finish_interval");
    issue_read(0, F_TXN_CNT, 1, "finish_ch0_txn");
  endtask

  task automatic test_out_of_range();
    issue_read(3, F_MIN_LAT, 0, "oor_min");
    issue_read(3, F_TS, 0, "oor_ts");
  endtask

  task automatic test_wrap();
    wait_ts((1 << CNT_W) - 3); pulse(0, 1, 1, 0);
    wait_ts(2); pulse(0, 0, 0, 1);
    issue_read(0, F_LAST_LAT, 5, "wrap_lat");
    issue_read(0, F_TXN_CNT, 2, "wrap_txn");
    issue_read(0, F_MIN_LAT, 5, "wrap_min");
    issue_read(0, F_MAX_LAT, 15, "wrap_max");
    issue_read(0, F_LAST_INTERVAL, (1 << CNT_W) - 3 - 10, "wrap_interval");
  endtask

  task automatic test_clear();
    wait_ts(20);
    clear = 1'b1; ap_done[2] = 1'b1;
    tick();
    clear = 1'b0; ap_done[2] = 1'b0;
    issue_read(2, F_TXN_CNT, 0, "clear_txn");
    issue_read(2, F_LAST_LAT, 0, "clear_last");
    issue_read(2, F_MIN_LAT, '1, "clear_min");
    issue_read(2, F_MAX_LAT, 0, "clear_max");
    issue_read(2, F_STATUS, 0, "clear_status");
    issue_read(0, F_LAST_INTERVAL, 0, "clear_ch0_interval");
    issue_read(0, F_TS, cyc, "clear_ts_running");
  endtask

  task automatic test_backpressure();
    logic [CNT_W-1:0] exp_stall;
`ifdef PERF_MON_STALL_EN
    exp_stall = 8;
`else
    exp_stall = 0;
`endif
    wait_ts(40);
    ap_start[2] = 1'b1; ap_ready[2] = 1'b0;
    repeat (2) tick();
    ap_ready[2] = 1'b1;
    tick();
    ap_start[2] = 1'b0; ap_ready[2] = 1'b0;
    wait_ts(50);
    ap_done[2] = 1'b1; ap_continue[2] = 1'b0;
    wait_ts(52);
    issue_read(2, F_STATUS, stv(ST_DONE_WAIT, 0, 0, 1), "bp_done_wait");
    wait_ts(56);
    ap_continue[2] = 1'b1;
    tick();
    ap_done[2] = 1'b0;
    issue_read(2, F_LAST_LAT, 56 - 42, "bp_lat");
    issue_read(2, F_TXN_CNT, 1, "bp_txn");
    issue_read(2, F_STATUS, stv(ST_IDLE, 0, 0, 0), "bp_idle");
    issue_read(2, F_STALL_CNT, exp_stall, "bp_stall");
  endtask

  task automatic test_async_reset();
    wait_ts(70); pulse(0, 1, 1, 0);
    rd_req = 1'b1; rd_ch = 2'd0; rd_field = F_STATUS;
    tick();
    rd_req = 1'b0;
    #2 reset = 1'b0;
    #1;
    total++;
    if (rd_valid !== 1'b0) begin bad++; $display("FAIL async_rd_valid: got %0b required 0", rd_valid); end
    total++;
    if (rd_data !== '0) begin bad++; $display("FAIL async_rd_data: got %0h required 0", rd_data); end
    repeat (2) @(negedge clock);
    reset = 1'b1;
    tick();
    issue_read(0, F_STATUS, 0, "async_status");
    issue_read(0, F_TXN_CNT, 0, "async_txn");
    issue_read(0, F_MIN_LAT, '1, "async_min");
    issue_read(0, F_TS, cyc, "async_ts");
  endtask

  initial begin
    reset       = 1'b1;
    ap_start    = '0;
    ap_ready    = '0;
    ap_done     = '0;
    ap_continue = '1;
    clear       = 1'b0;
    finish      = 1'b0;
    rd_req      = 1'b0;
    rd_ch       = '0;
    rd_field    = '0;
    #1;
    test_reset();
    test_single();
    test_overlap();
    test_overflow();
    test_same_cycle();
    test_underflow();
    test_finish();
    test_out_of_range();
    test_wrap();
    test_clear();
    test_backpressure();
    test_async_reset();
    repeat (3) tick();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL missing_responses: got %0d outstanding required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
